weight_read_sequencer: RTL and testbench

//   Sequences one neuron's weight memory for one pass over the input vector.

---
 rtl/weight_read_sequencer.sv | 110 +++++++++++
 tb/tb_weight_read_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_read_sequencer.sv
// Weight read sequencer: pairs each input sample with its weight from a
// 1-cycle registered weight memory. Optional bias fetch via BIAS_FETCH_EN.
module weight_read_sequencer #(
   parameter int numWeight    = 784,
   parameter int addressWidth = 10,
   parameter int dataWidth    = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  x_valid,
   input  logic [dataWidth-1:0]  x_data,
   output logic                  x_ready,
   output logic                  ren,
   output logic [addressWidth:0] raddr,
   input  logic [dataWidth-1:0]  wout,
   output logic                  mac_valid,
   output logic [dataWidth-1:0]  mac_x,
   output logic [dataWidth-1:0]  mac_w,
   output logic                  mac_last,
   output logic                  busy,
`ifdef BIAS_FETCH_EN
   output logic                  bias_valid,
   output logic [dataWidth-1:0]  bias_out,
`endif
   output logic                  done
);

   localparam int AW1 = addressWidth + 1;
   localparam logic [AW1-1:0] LAST_IDX = AW1'(numWeight - 1);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
`ifdef BIAS_FETCH_EN
      BIAS,
`endif
      DONE
   } state_t;

   state_t               state, state_n;
   logic [AW1-1:0]       cnt;
   logic [dataWidth-1:0] x_d;
   logic                 accept;
   logic                 at_last;

   assign x_ready = (state == RUN);
   assign accept  = x_valid & x_ready;
   assign at_last = (cnt == LAST_IDX);

   // cnt already sits at numWeight after the last accept, so it doubles as
   // the bias address without a separate mux.
   assign raddr = cnt;
   assign mac_x = x_d;
   assign mac_w = wout;
   assign busy  = (state != IDLE);
   assign done  = (state == DONE);

`ifdef BIAS_FETCH_EN
   assign ren      = accept | (state == BIAS);
   assign bias_out = wout;
`else
   assign ren      = accept;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (accept && at_last) state_n = DRAIN;
`ifdef BIAS_FETCH_EN
         DRAIN:   state_n = BIAS;
         BIAS:    state_n = DONE;
`else
         DRAIN:   state_n = DONE;
`endif
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt       <= '0;
         x_d       <= '0;
         mac_valid <= 1'b0;
         mac_last  <= 1'b0;
      end else begin
         if (state == IDLE && start) cnt <= '0;
         else if (accept)            cnt <= cnt + 1'b1;
         if (accept) x_d <= x_data;
         mac_valid <= accept;
         mac_last  <= accept & at_last;
      end
   end

`ifdef BIAS_FETCH_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) bias_valid <= 1'b0;
      else       bias_valid <= (state == BIAS);
   end
`endif

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Directed bench for weight_read_sequencer: one 4-weight and one 1-weight
// instance, each fed by a registered-read memory model.
module tb_weight_read_sequencer;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // 4-weight instance
   logic        start4, xv4, xr4, ren4, mv4, ml4, busy4, done4;
   logic [15:0] x4, wout4, mx4, mw4;
   logic [10:0] raddr4;
   logic [15:0] mem4 [0:7];
`ifdef BIAS_FETCH_EN
   logic        bv4;
   logic [15:0] bo4;
`endif

   // 1-weight instance
   logic        start1, xv1, xr1, ren1, mv1, ml1, busy1, done1;
   logic [15:0] x1, wout1, mx1, mw1;
   logic [10:0] raddr1;
   logic [15:0] mem1 [0:1];
`ifdef BIAS_FETCH_EN
   logic        bv1;
   logic [15:0] bo1;
`endif

   weight_read_sequencer #(.numWeight(4), .addressWidth(10), .dataWidth(16)) u4 (
      .clk(clk), .rstn(rstn), .start(start4), .x_valid(xv4), .x_data(x4),
      .x_ready(xr4), .ren(ren4), .raddr(raddr4), .wout(wout4),
      .mac_valid(mv4), .mac_x(mx4), .mac_w(mw4), .mac_last(ml4), .busy(busy4),
`ifdef BIAS_FETCH_EN
      .bias_valid(bv4), .bias_out(bo4),
`endif
      .done(done4));

   weight_read_sequencer #(.numWeight(1), .addressWidth(10), .dataWidth(16)) u1 (
      .clk(clk), .rstn(rstn), .start(start1), .x_valid(xv1), .x_data(x1),
      .x_ready(xr1), .ren(ren1), .raddr(raddr1), .wout(wout1),
      .mac_valid(mv1), .mac_x(mx1), .mac_w(mw1), .mac_last(ml1), .busy(busy1),
`ifdef BIAS_FETCH_EN
      .bias_valid(bv1), .bias_out(bo1),
`endif
      .done(done1));

   always @(posedge clk) if (ren4) wout4 <= mem4[raddr4[2:0]];
   always @(posedge clk) if (ren1) wout1 <= mem1[raddr1[0]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive4(input logic st, input logic v, input logic [15:0] x);
      @(negedge clk);
      start4 = st; xv4 = v; x4 = x;
      #1;
   endtask

   task automatic accept_chk(input string tag, input int addr);
      chk({tag, " ren"}, 32'(ren4), 32'd1);
      chk({tag, " raddr"}, 32'(raddr4), 32'(addr));
   endtask

   task automatic pair_chk(input string tag, input int x, input int w, input logic last);
      chk({tag, " mac_valid"}, 32'(mv4), 32'd1);
      chk({tag, " mac_x"}, 32'(mx4), 32'(x));
      chk({tag, " mac_w"}, 32'(mw4), 32'(w));
      chk({tag, " mac_last"}, 32'(ml4), 32'(last));
   endtask

   // Cycles after DRAIN: optional bias fetch, then the done pulse, then IDLE.
   task automatic finish4(input string tag);
`ifdef BIAS_FETCH_EN
      drive4(1'b0, 1'b0, 16'd0);
      chk({tag, " bias ren"}, 32'(ren4), 32'd1);
      chk({tag, " bias raddr"}, 32'(raddr4), 32'd4);
      chk({tag, " bias done"}, 32'(done4), 32'd0);
      drive4(1'b0, 1'b0, 16'd0);
      chk({tag, " bias_valid"}, 32'(bv4), 32'd1);
      chk({tag, " bias_out"}, 32'(bo4), 32'd99);
`else
      drive4(1'b0, 1'b0, 16'd0);
`endif
      chk({tag, " done"}, 32'(done4), 32'd1);
      chk({tag, " done mac_valid"}, 32'(mv4), 32'd0);
      drive4(1'b0, 1'b0, 16'd0);
      chk({tag, " done off"}, 32'(done4), 32'd0);
      chk({tag, " idle busy"}, 32'(busy4), 32'd0);
   endtask

   initial begin
      mem4[0] = 16'd10; mem4[1] = 16'd20; mem4[2] = 16'd30; mem4[3] = 16'd40;
      mem4[4] = 16'd99; mem4[5] = 16'd0;  mem4[6] = 16'd0;  mem4[7] = 16'd0;
      mem1[0] = 16'd5;  mem1[1] = 16'd33;
      wout4 = '0; wout1 = '0;
      start4 = 0; xv4 = 0; x4 = '0;
      start1 = 0; xv1 = 0; x1 = '0;

      // 1: reset, then idle outputs
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst x_ready", 32'(xr4), 32'd0);
      chk("rst ren", 32'(ren4), 32'd0);
      chk("rst mac_valid", 32'(mv4), 32'd0);
      chk("rst busy", 32'(busy4), 32'd0);
      chk("rst done", 32'(done4), 32'd0);
      chk("rst raddr", 32'(raddr4), 32'd0);
      rstn = 1'b1;

      // 2: continuous stream of four samples
      drive4(1'b1, 1'b0, 16'd0);
      chk("t2 idle x_ready", 32'(xr4), 32'd0);
      drive4(1'b0, 1'b1, 16'd1);
      chk("t2 busy", 32'(busy4), 32'd1);
      accept_chk("t2 s0", 0);
      chk("t2 s0 mac_valid", 32'(mv4), 32'd0);
      for (int i = 1; i < 4; i++) begin
         drive4(1'b0, 1'b1, 16'(i + 1));
         accept_chk("t2 s", i);
         pair_chk("t2 p", i, 10 * i, 1'b0);
      end
      drive4(1'b0, 1'b0, 16'd0);
      chk("t2 drain ren", 32'(ren4), 32'd0);
      chk("t2 drain x_ready", 32'(xr4), 32'd0);
      pair_chk("t2 p4", 4, 40, 1'b1);
      chk("t2 drain done", 32'(done4), 32'd0);
      finish4("t2");

      // 3: three-cycle x_valid gap after the second sample
      drive4(1'b1, 1'b0, 16'd0);
      drive4(1'b0, 1'b1, 16'd1);
      accept_chk("t3 s0", 0);
      drive4(1'b0, 1'b1, 16'd2);
      accept_chk("t3 s1", 1);
      pair_chk("t3 p1", 1, 10, 1'b0);
      drive4(1'b0, 1'b0, 16'd0);
      chk("t3 gap0 ren", 32'(ren4), 32'd0);
      pair_chk("t3 p2", 2, 20, 1'b0);
      for (int g = 1; g < 3; g++) begin
         drive4(1'b0, 1'b0, 16'd0);
         chk("t3 gap ren", 32'(ren4), 32'd0);
         chk("t3 gap mac_valid", 32'(mv4), 32'd0);
      end
      drive4(1'b0, 1'b1, 16'd3);
      accept_chk("t3 s2", 2);
      chk("t3 resume mac_valid", 32'(mv4), 32'd0);
      drive4(1'b0, 1'b1, 16'd4);
      accept_chk("t3 s3", 3);
      pair_chk("t3 p3", 3, 30, 1'b0);
      drive4(1'b0, 1'b0, 16'd0);
      pair_chk("t3 p4", 4, 40, 1'b1);
      finish4("t3");

      // 4: single-weight neuron
      @(negedge clk); start1 = 1'b1; #1;
      @(negedge clk); start1 = 1'b0; xv1 = 1'b1; x1 = 16'd7; #1;
      chk("t4 ren", 32'(ren1), 32'd1);
      chk("t4 raddr", 32'(raddr1), 32'd0);
      @(negedge clk); xv1 = 1'b0; #1;
      chk("t4 mac_valid", 32'(mv1), 32'd1);
      chk("t4 mac_x", 32'(mx1), 32'd7);
      chk("t4 mac_w", 32'(mw1), 32'd5);
      chk("t4 mac_last", 32'(ml1), 32'd1);
      chk("t4 x_ready", 32'(xr1), 32'd0);
`ifdef BIAS_FETCH_EN
      @(negedge clk); #1;
      chk("t4 bias raddr", 32'(raddr1), 32'd1);
      @(negedge clk); #1;
      chk("t4 bias_valid", 32'(bv1), 32'd1);
      chk("t4 bias_out", 32'(bo1), 32'd33);
`else
      @(negedge clk); #1;
`endif
      chk("t4 done", 32'(done1), 32'd1);
      chk("t4 done mac_valid", 32'(mv1), 32'd0);

      // 5: reset mid-pass, then restart (start with x_valid is not an accept)
      drive4(1'b1, 1'b0, 16'd0);
      drive4(1'b0, 1'b1, 16'd1);
      drive4(1'b0, 1'b1, 16'd2);
      drive4(1'b0, 1'b0, 16'd0);
      rstn = 1'b0; #1;
      chk("t5 abort busy", 32'(busy4), 32'd0);
      chk("t5 abort mac_valid", 32'(mv4), 32'd0);
      chk("t5 abort x_ready", 32'(xr4), 32'd0);
      drive4(1'b0, 1'b0, 16'd0);
      rstn = 1'b1;
      chk("t5 no done", 32'(done4), 32'd0);
      drive4(1'b0, 1'b0, 16'd0);
      chk("t5 no done2", 32'(done4), 32'd0);
      chk("t5 idle busy", 32'(busy4), 32'd0);
      drive4(1'b1, 1'b1, 16'd5);
      chk("t5 start-cycle ren", 32'(ren4), 32'd0);
      drive4(1'b0, 1'b1, 16'd5);
      accept_chk("t5 restart", 0);
      for (int i = 1; i < 4; i++) begin
         drive4(1'b0, 1'b1, 16'(i + 5));
         accept_chk("t5 s", i);
         pair_chk("t5 p", i + 4, 10 * i, 1'b0);
      end
      drive4(1'b0, 1'b0, 16'd0);
      pair_chk("t5 p4", 8, 40, 1'b1);
      finish4("t5");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
